// File: rtl/sd_write.sv
// SPI-mode SD single-block write engine (CMD24): command, R1, token, 512 data bytes, CRC,
// data response and busy poll. Define SD_WR_CRC16_EN to send a real CRC16-CCITT over the data.
module sd_write #(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BYTE = 0,
    parameter int R1_MAX    = 8,
    parameter int BUSY_MAX  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_o,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_data_req,
    output logic        wr_busy,
    output logic        wr_done,
    output logic        wr_err,
    output logic [2:0]  wr_status,
    input  logic        SD_MISO,
    output logic        SD_MOSI,
    output logic        SD_CSn,
    output logic        SD_CK
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_RESP, S_BUSY, S_ERR, S_TAIL
    } state_t;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_R1_TO   = 3'd1;
    localparam logic [2:0] ST_R1_BAD  = 3'd2;
    localparam logic [2:0] ST_CRC     = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_BUSY_TO = 3'd5;

    state_t      state_q, state_d;
    logic [31:0] arg_q, arg_in;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  data_cnt_q, data_cnt_d;
    logic [2:0]  status_q, status_d;
    logic [7:0]  data_buf_q;
    logic        data_cap_q;
    logic        req_q, req_d;
    logic        busy_q, done_q, err_q, csn_q;
    logic        accept, finish;

    logic        active_q, half_q, sck_q;
    logic [7:0]  div_q;
    logic [2:0]  bit_q;
    logic [7:0]  tx_q, rx_q;
    logic        tick, byte_end, load;
    logic [7:0]  load_byte;
    logic [7:0]  crc_hi, crc_lo;

    assign arg_in   = (ADDR_BYTE != 0) ? {wr_addr[22:0], 9'd0} : wr_addr;
    assign tick     = active_q && (div_q == 8'(CLK_DIV - 1));
    assign byte_end = tick && half_q && (bit_q == 3'd7);

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] arg);
        case (idx)
            3'd0:    cmd_byte = 8'h58;
            3'd1:    cmd_byte = arg[31:24];
            3'd2:    cmd_byte = arg[23:16];
            3'd3:    cmd_byte = arg[15:8];
            3'd4:    cmd_byte = arg[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    endfunction

    // The next byte is chosen on the clk its predecessor ends, so bytes run back-to-back.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_cnt_d = data_cnt_q;
        status_d   = status_q;
        load       = 1'b0;
        load_byte  = 8'hFF;
        req_d      = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: if (wr_req && init_o) begin
                accept    = 1'b1;
                state_d   = S_CMD;
                load      = 1'b1;
                load_byte = 8'h58;
                cnt_d     = '0;
                status_d  = ST_OK;
            end
            S_CMD: if (byte_end) begin
                load = 1'b1;
                if (cnt_q == 16'd5) begin
                    state_d = S_R1;
                    cnt_d   = '0;
                end else begin
                    load_byte = cmd_byte(cnt_q[2:0] + 3'd1, arg_q);
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            S_R1: if (byte_end) begin
                if (!rx_q[7]) begin
                    if (rx_q == 8'h00) begin
                        state_d = S_GAP;
                        load    = 1'b1;
                    end else begin
                        state_d  = S_ERR;
                        status_d = ST_R1_BAD;
                    end
                end else if (cnt_q == 16'(R1_MAX - 1)) begin
                    state_d  = S_ERR;
                    status_d = ST_R1_TO;
                end else begin
                    load  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: if (byte_end) begin
                state_d   = S_TOKEN;
                load      = 1'b1;
                load_byte = 8'hFE;
                req_d     = 1'b1;
            end
            S_TOKEN: if (byte_end) begin
                state_d    = S_DATA;
                load       = 1'b1;
                load_byte  = data_buf_q;
                data_cnt_d = '0;
                req_d      = 1'b1;
            end
            S_DATA: if (byte_end) begin
                load = 1'b1;
                if (data_cnt_q == 10'd511) begin
                    state_d   = S_CRC;
                    load_byte = crc_hi;
                    cnt_d     = '0;
                end else begin
                    load_byte  = data_buf_q;
                    data_cnt_d = data_cnt_q + 10'd1;
                    req_d      = (data_cnt_q < 10'd510);
                end
            end
            S_CRC: if (byte_end) begin
                load = 1'b1;
                if (cnt_q == 16'd0) begin
                    load_byte = crc_lo;
                    cnt_d     = 16'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: if (byte_end) begin
                case (rx_q[4:0])
                    5'h05: begin
                        state_d = S_BUSY;
                        load    = 1'b1;
                        cnt_d   = '0;
                    end
                    5'h0B: begin
                        state_d  = S_ERR;
                        status_d = ST_CRC;
                    end
                    default: begin
                        state_d  = S_ERR;
                        status_d = ST_WRITE;
                    end
                endcase
            end
            S_BUSY: if (byte_end) begin
                if (rx_q == 8'hFF) begin
                    state_d = S_TAIL;
                    load    = 1'b1;
                end else if (cnt_q == 16'(BUSY_MAX - 1)) begin
                    state_d  = S_ERR;
                    status_d = ST_BUSY_TO;
                end else begin
                    load  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ERR: begin
                state_d = S_TAIL;
                load    = 1'b1;
            end
            S_TAIL: if (byte_end) begin
                state_d = S_IDLE;
                finish  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            arg_q      <= '0;
            cnt_q      <= '0;
            data_cnt_q <= '0;
            status_q   <= ST_OK;
            req_q      <= 1'b0;
            data_cap_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csn_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_cnt_q <= data_cnt_d;
            status_q   <= status_d;
            if (accept) arg_q <= arg_in;
            req_q      <= req_d;
            data_cap_q <= req_q;
            busy_q     <= accept | (busy_q & ~finish);
            done_q     <= finish && (status_q == ST_OK);
            err_q      <= finish && (status_q != ST_OK);
            csn_q      <= (state_d == S_IDLE) || (state_d == S_ERR) || (state_d == S_TAIL);
        end
    end

    // NOTE: the data byte buffer is pure datapath, rewritten before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (data_cap_q) data_buf_q <= wr_data;
    end

    // Mode-0 byte engine: MOSI is tx_q[7]; it shifts on the falling edge, MISO samples on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            half_q   <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= 8'hFF;
            rx_q     <= 8'hFF;
        end else if (load) begin
            active_q <= 1'b1;
            half_q   <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= load_byte;
        end else if (tick) begin
            div_q <= '0;
            if (!half_q) begin
                sck_q  <= 1'b1;
                half_q <= 1'b1;
                rx_q   <= {rx_q[6:0], SD_MISO};
            end else begin
                sck_q  <= 1'b0;
                half_q <= 1'b0;
                if (bit_q == 3'd7) begin
                    active_q <= 1'b0;
                    tx_q     <= 8'hFF;
                end else begin
                    bit_q <= bit_q + 3'd1;
                    tx_q  <= {tx_q[6:0], 1'b1};
                end
            end
        end else if (active_q) begin
            div_q <= div_q + 8'd1;
        end
    end

`ifdef SD_WR_CRC16_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (load && state_d == S_TOKEN) begin
            crc_q <= '0;
        end else if (load && state_d == S_DATA) begin
            crc_q <= crc16_step(crc_q, load_byte);
        end
    end

    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    assign wr_data_req = req_q;
    assign wr_busy     = busy_q;
    assign wr_done     = done_q;
    assign wr_err      = err_q;
    assign wr_status   = status_q;
    assign SD_MOSI     = tx_q[7];
    assign SD_CSn      = csn_q;
    assign SD_CK       = sck_q;

endmodule

// File: tb/tb_sd_write.sv
// Directed bench for sd_write: a scripted SPI card answers by byte position, a monitor logs MOSI
// bytes, feeds wr_data and counts pulses for whichever of three DUT builds is selected.
module tb_sd_write;

    localparam int SC_MAIN = 0, SC_NORESP = 1, SC_REJ = 2, SC_BUSY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init_o, miso;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  wr_req, req, busy, done, err, mosi, csn, ck;
    logic [2:0]  status [3];

    sd_write #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_o(init_o), .wr_req(wr_req[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_req(req[0]), .wr_busy(busy[0]), .wr_done(done[0]),
        .wr_err(err[0]), .wr_status(status[0]), .SD_MISO(miso), .SD_MOSI(mosi[0]),
        .SD_CSn(csn[0]), .SD_CK(ck[0])
    );
    sd_write #(.CLK_DIV(1), .ADDR_BYTE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .init_o(init_o), .wr_req(wr_req[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_req(req[1]), .wr_busy(busy[1]), .wr_done(done[1]),
        .wr_err(err[1]), .wr_status(status[1]), .SD_MISO(miso), .SD_MOSI(mosi[1]),
        .SD_CSn(csn[1]), .SD_CK(ck[1])
    );
    sd_write #(.CLK_DIV(1), .BUSY_MAX(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .init_o(init_o), .wr_req(wr_req[2]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_req(req[2]), .wr_busy(busy[2]), .wr_done(done[2]),
        .wr_err(err[2]), .wr_status(status[2]), .SD_MISO(miso), .SD_MOSI(mosi[2]),
        .SD_CSn(csn[2]), .SD_CK(ck[2])
    );

    int         n_cmp = 0, n_bad = 0;
    int         sel = 0, scen = SC_NORESP;
    bit         all_ff = 1'b0;
    logic [7:0] mlog [$];
    int         rise_cnt, tail_rise, tail_bad, req_cnt, done_cnt, err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k, input bit ff);
        return ff ? 8'hFF : (8'(k) ^ 8'h5A);
    endfunction

    function automatic logic [15:0] crc_model(input bit ff);
        logic [15:0] c = 16'h0000;
        logic [7:0]  d;
        for (int k = 0; k < 512; k++) begin
            d = pat(k, ff);
            for (int b = 7; b >= 0; b--) begin
                if (c[15] != d[b]) c = (c << 1) ^ 16'h1021;
                else               c = c << 1;
            end
        end
        return c;
    endfunction

    // Card answer by byte position since CSn fell: 0-5 cmd, 6.. R1 polls, 524 data response.
    function automatic logic [7:0] miso_byte(input int idx);
        case (scen)
            SC_MAIN:   return (idx == 7 || (idx >= 525 && idx <= 527)) ? 8'h00 :
                              (idx == 524) ? 8'hE5 : 8'hFF;
            SC_REJ:    return (idx == 7) ? 8'h00 : (idx == 524) ? 8'hEB : 8'hFF;
            SC_BUSY:   return (idx == 7 || idx >= 525) ? 8'h00 : (idx == 524) ? 8'hE5 : 8'hFF;
            default:   return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] logb(input int i);
        return (i < mlog.size()) ? {24'd0, mlog[i]} : 32'h100;
    endfunction

    initial begin
        logic       prev_ck = 1'b0;
        logic [7:0] sh = 8'h00;
        logic [7:0] b;
        miso    = 1'b1;
        wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!csn[sel] && ck[sel] && !prev_ck) begin
                sh = {sh[6:0], mosi[sel]};
                rise_cnt++;
                if (rise_cnt % 8 == 0) mlog.push_back(sh);
            end
            if (csn[sel] && ck[sel] && !prev_ck) begin
                tail_rise++;
                if (!mosi[sel]) tail_bad++;
            end
            prev_ck = ck[sel];
            if (req[sel]) begin
                wr_data = pat(req_cnt, all_ff);
                req_cnt++;
            end
            if (done[sel]) done_cnt++;
            if (err[sel]) err_cnt++;
            b    = miso_byte(rise_cnt / 8);
            miso = csn[sel] ? 1'b1 : b[3'(7 - rise_cnt % 8)];
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int s, input int sc, input logic [31:0] addr, input bit ff);
        sel = s; scen = sc; all_ff = ff;
        mlog.delete();
        rise_cnt = 0; tail_rise = 0; tail_bad = 0; req_cnt = 0; done_cnt = 0; err_cnt = 0;
        wr_addr   = addr;
        wr_req[s] = 1'b1;
        tick_n(1);
        wr_req[s] = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done[sel] || err[sel]) && n < budget) begin
            tick_n(1);
            n++;
        end
        check({tag, "_end_seen"}, 32'(n < budget), 1);
        tick_n(6);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ck"}, ck[0], 0);
        check({tag, "_mosi"}, mosi[0], 1);
        check({tag, "_csn"}, csn[0], 1);
        check({tag, "_busy"}, busy[0], 0);
        check({tag, "_done"}, done[0], 0);
        check({tag, "_err"}, err[0], 0);
        check({tag, "_req"}, req[0], 0);
        check({tag, "_status"}, status[0], 0);
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] arg);
        logic [7:0] exp [6];
        exp = '{8'h58, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 8'hFF};
        for (int i = 0; i < 6; i++) check($sformatf("%s_cmd%0d", tag, i), logb(i), exp[i]);
    endtask

    task automatic check_body(input string tag, input bit ff);
        int         bad = 0;
        logic [15:0] crc_exp;
`ifdef SD_WR_CRC16_EN
        crc_exp = crc_model(ff);
`else
        crc_exp = 16'hFFFF;
`endif
        check({tag, "_poll0"}, logb(6), 8'hFF);
        check({tag, "_gap"}, logb(8), 8'hFF);
        check({tag, "_token"}, logb(9), 8'hFE);
        for (int k = 0; k < 512; k++) if (logb(10 + k) != {24'd0, pat(k, ff)}) bad++;
        check({tag, "_data"}, bad, 0);
        check({tag, "_crc_hi"}, logb(522), crc_exp[15:8]);
        check({tag, "_crc_lo"}, logb(523), crc_exp[7:0]);
        check({tag, "_reqs"}, req_cnt, 512);
    endtask

    initial begin
        rst_n = 1'b0; init_o = 1'b0; wr_req = '0; wr_addr = '0;
        tick_n(3);
        check_reset("rst");
        rst_n = 1'b1;
        tick_n(2);

        // Request without init_o is ignored.
        wr_req[0] = 1'b1; tick_n(1); wr_req[0] = 1'b0;
        tick_n(40);
        check("noinit_busy", busy[0], 0);
        check("noinit_csn", csn[0], 1);

        // Full successful write; a second wr_req and init_o falling mid-transfer are ignored.
        init_o = 1'b1;
        start(0, SC_MAIN, 32'h0000_0010, 1'b0);
        tick_n(50);
        check("main_busy", busy[0], 1);
        wr_addr = 32'hFFFF_FFFF; wr_req[0] = 1'b1; tick_n(1); wr_req[0] = 1'b0;
        tick_n(1000);
        init_o = 1'b0;
        wait_end("main", 20000);
        init_o = 1'b1;
        check("main_len", mlog.size(), 529);
        check_cmd("main", 32'h0000_0010);
        check_body("main", 1'b0);
        check("main_resp_tx", logb(524), 8'hFF);
        check("main_done", done_cnt, 1);
        check("main_err", err_cnt, 0);
        check("main_status", status[0], 0);
        check("main_tail", tail_rise, 8);
        check("main_tail_mosi", tail_bad, 0);
        check("main_busy_end", busy[0], 0);

        // Byte addressing, card never answers: R1 timeout after 8 polls.
        start(1, SC_NORESP, 32'h0000_0003, 1'b0);
        wait_end("r1to", 2000);
        check("r1to_len", mlog.size(), 14);
        check_cmd("r1to", 32'h0000_0600);
        check("r1to_err", err_cnt, 1);
        check("r1to_done", done_cnt, 0);
        check("r1to_status", status[1], 1);
        check("r1to_reqs", req_cnt, 0);
        check("r1to_tail", tail_rise, 8);

        // Data response 0xEB: CRC reject.
        start(2, SC_REJ, 32'h0000_0020, 1'b0);
        wait_end("rej", 12000);
        check("rej_len", mlog.size(), 525);
        check("rej_err", err_cnt, 1);
        check("rej_done", done_cnt, 0);
        check("rej_status", status[2], 3);
        check("rej_reqs", req_cnt, 512);

        // Busy never releases with BUSY_MAX=4.
        start(2, SC_BUSY, 32'h0000_0021, 1'b0);
        wait_end("bto", 12000);
        check("bto_len", mlog.size(), 529);
        check("bto_err", err_cnt, 1);
        check("bto_status", status[2], 5);

        // Reset during data byte 100 aborts with no completion pulse.
        begin
            int n = 0;
            start(0, SC_MAIN, 32'h0000_0010, 1'b0);
            while (mlog.size() < 110 && n < 10000) begin
                tick_n(1);
                n++;
            end
            check("arst_reach", 32'(n < 10000), 1);
        end
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        tick_n(2);
        rst_n = 1'b1;
        tick_n(60);
        check("arst_no_done", done_cnt, 0);
        check("arst_no_err", err_cnt, 0);

        // Following write with all-0xFF data completes and carries the expected CRC bytes.
        start(0, SC_MAIN, 32'h0000_0010, 1'b1);
        wait_end("ff", 20000);
        check("ff_len", mlog.size(), 529);
        check_cmd("ff", 32'h0000_0010);
        check_body("ff", 1'b1);
`ifdef SD_WR_CRC16_EN
        check("ff_crc_const", {logb(522)[7:0], logb(523)[7:0]}, 16'h7FA1);
`else
        check("ff_crc_const", {logb(522)[7:0], logb(523)[7:0]}, 16'hFFFF);
`endif
        check("ff_done", done_cnt, 1);
        check("ff_status", status[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
